// File: rtl/cellrv32_trng_arbiter_if.sv
// Requester handshake and TRNG register bus of cellrv32_trng_arbiter.
// master: the arbiter itself; slave: requesters plus the TRNG bus slave.
interface cellrv32_trng_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] ack_o;
  logic [NUM_REQ-1:0] err_o;
  logic [31:0]        rnd_o;
  logic               busy_o;
  logic [31:0]        trng_addr_o;
  logic               trng_rden_o;
  logic               trng_wren_o;
  logic [31:0]        trng_data_o;
  logic [31:0]        trng_data_i;
  logic               trng_ack_i;

  modport master (
    input  req_i, trng_data_i, trng_ack_i,
    output ack_o, err_o, rnd_o, busy_o,
           trng_addr_o, trng_rden_o, trng_wren_o, trng_data_o
  );

  modport slave (
    output req_i, trng_data_i, trng_ack_i,
    input  ack_o, err_o, rnd_o, busy_o,
           trng_addr_o, trng_rden_o, trng_wren_o, trng_data_o
  );
endinterface

// File: rtl/cellrv32_trng_arbiter.sv
// Round-robin owner of the TRNG register: packs 4 valid bytes into one word per granted request.
// Define CELLRV32_TRNG_ARB_HEALTH_EN to add a repetition-count health test on accepted bytes.
module cellrv32_trng_arbiter #(
  parameter int          NUM_REQ    = 2,
  parameter logic [31:0] TRNG_BASE  = 32'hFFFFFFB8,
  parameter int          POLL_LIMIT = 1024,
  parameter int          REP_LIMIT  = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  cellrv32_trng_arbiter_if.master bus
);
  localparam int            GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int            PW        = $clog2(POLL_LIMIT + 1);
  localparam logic [31:0]   CTRL_INIT = 32'h5000_0000;
  localparam logic [PW-1:0] POLL_MAX  = PW'(POLL_LIMIT);
  localparam logic [GW:0]   NREQ_W    = (GW+1)'(NUM_REQ);

  typedef enum logic [2:0] {
    S_INIT, S_INIT_W, S_IDLE, S_POLL, S_POLL_W, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          run_q;
  logic          restart_q, restart_d;
  logic [GW-1:0] gnt_q, gnt_d, last_q, last_d;
  logic [2:0]    byte_q, byte_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [31:0]   word_q, word_d;

  logic               wren, rden, acc, busy;
  logic [NUM_REQ-1:0] ack, err, gnt_oh;
  logic [31:0]        rnd;
  logic               byte_vld, rep_trip;

  assign byte_vld = (state_q == S_POLL_W) && bus.trng_ack_i &&
                    bus.trng_data_i[31] && bus.trng_data_i[30];
  assign gnt_oh   = NUM_REQ'(1) << gnt_q;

  // Rotate requests so bit 0 is the index right after the last grant,
  // take the lowest set bit, then rotate back.
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [GW:0]          scan_base, pick_sum;
  logic [GW-1:0]        pick_off, pick;
  logic                 any_req;

  always_comb begin
    any_req   = |bus.req_i;
    scan_base = {1'b0, last_q} + (GW+1)'(1);
    req_dbl   = {bus.req_i, bus.req_i} >> scan_base;
    pick_off  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_dbl[i]) pick_off = GW'(i);
    pick_sum = scan_base + {1'b0, pick_off};
    if (pick_sum >= NREQ_W) pick_sum = pick_sum - NREQ_W;
    pick = pick_sum[GW-1:0];
  end

`ifdef CELLRV32_TRNG_ARB_HEALTH_EN
  localparam int            RW       = $clog2(REP_LIMIT + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REP_LIMIT - 1);

  logic [7:0]    rep_byte_q;
  logic [RW-1:0] rep_cnt_q;
  logic          rep_same;

  assign rep_same = (rep_cnt_q != '0) && (bus.trng_data_i[7:0] == rep_byte_q);
  assign rep_trip = byte_vld && rep_same && (rep_cnt_q == REP_LAST);

  // Run length spans request boundaries; only a differing byte, a trip or reset restarts it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rep_byte_q <= '0;
      rep_cnt_q  <= '0;
    end else if (byte_vld) begin
      if (rep_trip) begin
        rep_cnt_q <= '0;
      end else if (rep_same) begin
        rep_cnt_q <= rep_cnt_q + RW'(1);
      end else begin
        rep_cnt_q  <= RW'(1);
        rep_byte_q <= bus.trng_data_i[7:0];
      end
    end
  end
`else
  // Health test compiled out: never trips.
  assign rep_trip = (REP_LIMIT < 0);
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_INIT;
      run_q     <= 1'b0;
      restart_q <= 1'b0;
      gnt_q     <= '0;
      last_q    <= GW'(NUM_REQ - 1);
      byte_q    <= '0;
      poll_q    <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      restart_q <= restart_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      byte_q    <= byte_d;
      poll_q    <= poll_d;
      word_q    <= word_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    restart_d = restart_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    byte_d    = byte_q;
    poll_d    = poll_q;
    word_d    = word_q;
    wren      = 1'b0;
    rden      = 1'b0;
    acc       = 1'b0;
    busy      = 1'b0;
    ack       = '0;
    err       = '0;
    rnd       = '0;
    unique case (state_q)
      // run_q keeps every output low during the first cycle out of reset
      S_INIT: begin
        if (run_q) begin
          wren      = 1'b1;
          acc       = 1'b1;
          restart_d = 1'b0;
          state_d   = S_INIT_W;
        end
      end
      S_INIT_W: begin
        acc = 1'b1;
        if (bus.trng_ack_i) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = pick;
          last_d  = pick;
          byte_d  = '0;
          poll_d  = '0;
          word_d  = '0;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        busy    = 1'b1;
        rden    = 1'b1;
        acc     = 1'b1;
        poll_d  = poll_q + PW'(1);
        state_d = S_POLL_W;
      end
      S_POLL_W: begin
        busy = 1'b1;
        acc  = 1'b1;
        if (bus.trng_ack_i) begin
          if (!bus.trng_data_i[30] || rep_trip) begin
            restart_d = 1'b1;
            state_d   = S_ERR;
          end else begin
            if (byte_vld) begin
              word_d[{byte_q[1:0], 3'b000} +: 8] = bus.trng_data_i[7:0];
              byte_d = byte_q + 3'd1;
            end
            if (byte_vld && byte_q == 3'd3) state_d = S_DONE;
            else if (poll_q == POLL_MAX)    state_d = S_ERR;
            else                            state_d = S_POLL;
          end
        end
      end
      S_DONE: begin
        ack     = gnt_oh;
        rnd     = word_q;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = gnt_oh;
        word_d  = '0;
        state_d = restart_q ? S_INIT : S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign bus.ack_o       = ack;
  assign bus.err_o       = err;
  assign bus.rnd_o       = rnd;
  assign bus.busy_o      = busy;
  assign bus.trng_rden_o = rden;
  assign bus.trng_wren_o = wren;
  assign bus.trng_addr_o = acc  ? TRNG_BASE : 32'h0;
  assign bus.trng_data_o = wren ? CTRL_INIT : 32'h0;

  logic unused_data_bits;
  assign unused_data_bits = ^bus.trng_data_i[29:8];
endmodule

// File: tb/tb_cellrv32_trng_arbiter.sv
// Directed bench for cellrv32_trng_arbiter: vector table plus multi-cycle sequences,
// against a TRNG slave model that acks one cycle after each strobe.
module tb_cellrv32_trng_arbiter;
  localparam int          NREQ = 2;
  localparam logic [31:0] BASE = 32'hFFFFFFB8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cellrv32_trng_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  cellrv32_trng_arbiter #(
    .NUM_REQ(NREQ), .TRNG_BASE(BASE), .POLL_LIMIT(8), .REP_LIMIT(8)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TRNG slave model: words queued by the test; empty queue reads "enabled, not valid"
  logic [31:0] trng_q[$];
  int          rd_cnt = 0, wr_cnt = 0, wr_cyc = 0;
  logic [31:0] wr_data = '0, wr_addr = '0;

  initial begin
    logic p_rd, p_wr;
    bus.trng_ack_i  = 1'b0;
    bus.trng_data_i = '0;
    forever begin
      @(negedge clk);
      p_rd = bus.trng_rden_o;
      p_wr = bus.trng_wren_o;
      if (p_rd) rd_cnt++;
      if (p_wr) begin
        wr_cnt++;
        wr_cyc  = cyc;
        wr_data = bus.trng_data_o;
        wr_addr = bus.trng_addr_o;
      end
      @(posedge clk);
      #1;
      bus.trng_ack_i  = p_rd | p_wr;
      bus.trng_data_i = '0;
      if (p_rd) bus.trng_data_i = (trng_q.size() > 0) ? trng_q.pop_front() : 32'h4000_0000;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_busy(input string name, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.busy_o && n < 300);
    if (!bus.busy_o) begin
      checks++; errors++;
      $display("FAIL %s: no grant within %0d cycles", name, n);
    end
  endtask

  task automatic wait_resp(input string name, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.ack_o == '0 && bus.err_o == '0 && n < 300);
    if (bus.ack_o == '0 && bus.err_o == '0) begin
      checks++; errors++;
      $display("FAIL %s: no ack/err within %0d cycles", name, n);
    end
  endtask

  task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    trng_q.push_back({24'hC00000, b0});
    trng_q.push_back({24'hC00000, b1});
    trng_q.push_back({24'hC00000, b2});
    trng_q.push_back({24'hC00000, b3});
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    int              inv;
    logic [7:0]      b0, b1, b2, b3;
    logic [NREQ-1:0] ack;
    logic [31:0]     rnd;
    int              reads;
    int              lat;
  } vec_t;

  localparam int NV = 5;
  vec_t vt[NV];

  initial begin
    int n, m, r0, w0, bc;
    logic seen;
    logic [7:0] bv;
    logic [31:0] alt_rnd[4];

    vt[0] = '{2'b01, 0, 8'h11, 8'h22, 8'h33, 8'h44, 2'b01, 32'h44332211, 4, 9};
    vt[1] = '{2'b10, 0, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 2'b10, 32'hEFBEADDE, 4, 9};
    vt[2] = '{2'b01, 3, 8'h01, 8'h02, 8'h03, 8'h04, 2'b01, 32'h04030201, 7, 15};
    vt[3] = '{2'b01, 4, 8'h5A, 8'hA5, 8'hC3, 8'h3C, 2'b01, 32'h3CC3A55A, 8, 17};
    vt[4] = '{2'b10, 1, 8'hFF, 8'h00, 8'h80, 8'h7F, 2'b10, 32'h7F8000FF, 5, 11};
    alt_rnd = '{32'h83828180, 32'h87868584, 32'h8B8A8988, 32'h8F8E8D8C};

    // reset state, init write, no grant before its ack
    bus.req_i = 2'b01;
    push4(8'h10, 8'h20, 8'h30, 8'h40);
    repeat (3) @(negedge clk);
    check("rst ctl", 32'({bus.ack_o, bus.err_o, bus.busy_o, bus.trng_rden_o, bus.trng_wren_o}), 32'h0);
    check("rst rnd", bus.rnd_o, 32'h0);
    check("rst addr", bus.trng_addr_o, 32'h0);
    check("rst wdata", bus.trng_data_o, 32'h0);
    rstn = 1'b1;
    wait_busy("init grant", n);
    bc = cyc;
    check("init wr count", 32'(wr_cnt), 32'd1);
    check("init wr data", wr_data, 32'h5000_0000);
    check("init wr addr", wr_addr, BASE);
    check("grant after init ack", 32'(bc - wr_cyc), 32'd3);
    wait_resp("init req", m);
    check("init req ack", 32'(bus.ack_o), 32'h1);
    check("init req rnd", bus.rnd_o, 32'h40302010);
    check("init req reads", 32'(rd_cnt), 32'd4);
    bus.req_i = '0;
    @(negedge clk);

    // single requests: invalid polls, byte packing, latency, poll-limit boundary
    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < vt[i].inv; k++) trng_q.push_back(32'h4000_005A);
      push4(vt[i].b0, vt[i].b1, vt[i].b2, vt[i].b3);
      r0 = rd_cnt;
      bus.req_i = vt[i].req;
      wait_busy($sformatf("v%0d grant", i), n);
      wait_resp($sformatf("v%0d resp", i), m);
      check($sformatf("v%0d ack", i), 32'(bus.ack_o), 32'(vt[i].ack));
      check($sformatf("v%0d err", i), 32'(bus.err_o), 32'h0);
      check($sformatf("v%0d rnd", i), bus.rnd_o, vt[i].rnd);
      check($sformatf("v%0d reads", i), 32'(rd_cnt - r0), 32'(vt[i].reads));
      check($sformatf("v%0d latency", i), 32'(m + 1), 32'(vt[i].lat));
      bus.req_i = '0;
      @(negedge clk);
      check($sformatf("v%0d after", i), 32'({bus.ack_o, bus.busy_o}) | bus.rnd_o, 32'h0);
    end

    // both requesters held: grants alternate, one idle cycle between services
    for (int k = 0; k < 16; k++) begin
      bv = 8'h80 + 8'(k);
      trng_q.push_back({24'hC00000, bv});
    end
    bus.req_i = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_resp($sformatf("alt%0d resp", g), m);
      check($sformatf("alt%0d ack", g), 32'(bus.ack_o), (g % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("alt%0d rnd", g), bus.rnd_o, alt_rnd[g]);
      if (g < 3) begin
        wait_busy($sformatf("alt%0d regrant", g), n);
        check($sformatf("alt%0d gap", g), 32'(n), 32'd2);
      end
    end
    bus.req_i = '0;
    @(negedge clk);

    // timeout: never valid, error after exactly POLL_LIMIT reads
    trng_q.delete();
    r0 = rd_cnt;
    bus.req_i = 2'b01;
    wait_resp("timeout", m);
    check("timeout err", 32'(bus.err_o), 32'h1);
    check("timeout ack", 32'(bus.ack_o), 32'h0);
    check("timeout rnd", bus.rnd_o, 32'h0);
    check("timeout reads", 32'(rd_cnt - r0), 32'd8);
    check("timeout cycles", 32'(m), 32'd17);
    bus.req_i = '0;
    @(negedge clk);

    // TRNG found disabled: error, re-init write, then service resumes
    trng_q.push_back(32'h8000_0012);
    push4(8'h21, 8'h43, 8'h65, 8'h87);
    w0 = wr_cnt;
    bus.req_i = 2'b10;
    wait_resp("disabled", m);
    check("disabled err", 32'(bus.err_o), 32'h2);
    check("disabled ack", 32'(bus.ack_o), 32'h0);
    bus.req_i = 2'b01;
    @(negedge clk);
    wait_resp("after disabled", m);
    check("after disabled ack", 32'(bus.ack_o), 32'h1);
    check("after disabled rnd", bus.rnd_o, 32'h87654321);
    check("reinit writes", 32'(wr_cnt - w0), 32'd1);
    bus.req_i = '0;
    @(negedge clk);

    // reset mid-service: silent abandon, INIT re-run
    push4(8'h31, 8'h32, 8'h33, 8'h34);
    bus.req_i = 2'b10;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    bus.req_i = '0;
    @(negedge clk);
    check("abort outs", 32'({bus.ack_o, bus.err_o, bus.busy_o, bus.trng_rden_o, bus.trng_wren_o}), 32'h0);
    trng_q.delete();
    w0 = wr_cnt;
    seen = 1'b0;
    rstn = 1'b1;
    repeat (8) begin
      @(negedge clk);
      seen = seen | (|bus.ack_o) | (|bus.err_o);
    end
    check("abort no resp", 32'(seen), 32'h0);
    check("abort reinit", 32'(wr_cnt - w0), 32'd1);

    // eight identical bytes across two requests
    push4(8'hAA, 8'hAA, 8'hAA, 8'hAA);
    push4(8'hAA, 8'hAA, 8'hAA, 8'hAA);
    bus.req_i = 2'b01;
    wait_resp("rep1", m);
    check("rep1 ack", 32'(bus.ack_o), 32'h1);
    check("rep1 rnd", bus.rnd_o, 32'hAAAAAAAA);
    bus.req_i = '0;
    @(negedge clk);
    w0 = wr_cnt;
    bus.req_i = 2'b01;
    wait_resp("rep2", m);
`ifdef CELLRV32_TRNG_ARB_HEALTH_EN
    check("rep2 err", 32'(bus.err_o), 32'h1);
    check("rep2 ack", 32'(bus.ack_o), 32'h0);
    bus.req_i = '0;
    @(negedge clk);
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    bus.req_i = 2'b01;
    wait_resp("rep3", m);
    check("rep3 ack", 32'(bus.ack_o), 32'h1);
    check("rep3 rnd", bus.rnd_o, 32'h04030201);
    check("rep clear writes", 32'(wr_cnt - w0), 32'd1);
`else
    check("rep2 ack", 32'(bus.ack_o), 32'h1);
    check("rep2 rnd", bus.rnd_o, 32'hAAAAAAAA);
    check("rep no writes", 32'(wr_cnt - w0), 32'd0);
`endif
    bus.req_i = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
